multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle MIPS main controller; next generation of the combinational opcode-to-ALUOp control unit.
- A registered FSM sequences fetch, decode, execute, memory and writeback over several cycles, and drives all datapath enables per state.
- Stalls on a memory-ready handshake and counts retired instructions.
- Sits between instruction register opcode field and multi-cycle datapath (PC, IR, register file, ALU, unified memory).

Parameters:
OPCODE_WIDTH, 6, opcode input width; must be >=6; MIPS opcodes compared zero-extended to this width
ALUOP_WIDTH, 3, width of alu_op output; must be >=2
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  OPCODE_WIDTH  instruction opcode from IR
mem_ready  input  1  memory completes access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (branch)
i_or_d  output  1  0=PC addresses memory, 1=ALUOut addresses memory
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  IR/MDR capture
mem_to_reg  output  1  writeback source: 1=MDR, 0=ALUOut
reg_dst  output  1  1=rd, 0=rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2
pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
alu_op  output  ALUOP_WIDTH  0=add, 1=sub, 2=decode funct
state  output  4  current FSM state encoding
instr_count  output  CNT_WIDTH  retired instructions
illegal_op  output  1  sticky illegal-opcode flag

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010; all others illegal.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXECUTE=7, ALUWB=8, BRANCH=9, ADDIEXEC=10, ADDIWB=11, JUMP=12, TRAP=13.
- Reset at clk edge: state=IDLE, instr_count=0, illegal_op=0.
- IDLE: all control outputs 0. Next cycle goes to FETCH.
- Outputs are Moore-decoded from state. Exception: ir_write and pc_write in FETCH are additionally qualified by mem_ready.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add.
  - lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC; j -> JUMP; illegal -> see Optional Feature.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Held while mem_ready=0; goes to MEMWB when ready.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_write=1, i_or_d=1. Held while mem_ready=0; goes to FETCH when ready.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=2. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_src=01. Goes to FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=add. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- Outputs not listed for a state are 0.
- instr_count increments by 1 on every transition into FETCH from a non-IDLE state; wraps modulo 2^CNT_WIDTH.
- Latency from FETCH with mem_ready held 1: lw 5 cycles, R/sw/addi 4, beq/j 3.
- Request signals (mem_read/mem_write) remain asserted, and address select remains stable, for the whole stall.
- Reset mid-instruction (including mid-stall): next state is IDLE; no counter increment that cycle.
- opcode is sampled only in DECODE and MEMADR; changes at other times are ignored.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined: illegal opcode in DECODE goes to TRAP. TRAP drives all control outputs 0 and sets illegal_op=1 (sticky). TRAP is held until reset; instr_count is not incremented.
- Undefined: illegal opcode in DECODE goes to FETCH as a NOP and instr_count increments. TRAP is unreachable; illegal_op is tied 0.

Test Plan:
- Reset then lw (100011), mem_ready=1 -> states 0,1,2,3,4,5,1; reg_write=1 and mem_to_reg=1 only in state 5; instr_count=1.
- R-type (000000), mem_ready=1 -> 1,2,7,8,1; alu_op=2 in state 7; reg_dst=1 and reg_write=1 in state 8.
- sw (101011) with mem_ready low 3 cycles in MEMWR -> state 6 held 4 cycles; mem_write=1 and i_or_d=1 throughout; count +1 only on exit.
- beq then j back-to-back -> 1,2,9,1,2,12,1; pc_write_cond=1 in 9; pc_src=10 and pc_write=1 in 12; instr_count=2.
- FETCH with mem_ready=0 for 2 cycles -> ir_write=pc_write=0 for those cycles, then 1 for one cycle; assert reset during MEMRD stall -> state 0 next cycle, instr_count=0.
- Opcode 111111: with ILLEGAL_OP_TRAP_EN -> state 13, illegal_op=1 held 10 cycles, count unchanged; without it -> 2 to 1, count +1, illegal_op=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main controller.
// A registered Moore FSM steps each instruction through fetch, decode, execute,
// memory and writeback, stalls on mem_ready and counts retired instructions.
// Optional build macro: ILLEGAL_OP_TRAP_EN. When it is defined, an illegal opcode
// parks the FSM in TRAP and sets illegal_op. When it is not defined, an illegal
// opcode retires as a NOP and illegal_op stays 0.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset, all controls off
// FETCH    | read instruction at PC, PC <= PC+4 (waits for mem_ready)
// DECODE   | register read, ALUOut <= PC + (imm<<2) for branch target
// MEMADR   | ALUOut <= A + sign-ext imm (lw/sw address)
// MEMRD    | load read, MDR capture (waits for mem_ready)
// MEMWB    | rt <= MDR
// MEMWR    | store write (waits for mem_ready)
// EXECUTE  | R-type ALU operation
// ALUWB    | rd <= ALUOut
// BRANCH   | compare A-B, PC <= ALUOut if zero
// ADDIEXEC | ALUOut <= A + sign-ext imm
// ADDIWB   | rt <= ALUOut
// JUMP     | PC <= jump target
// TRAP     | illegal opcode, held until reset
module multicycle_control_unit #(
  parameter int OPCODE_WIDTH = 6,
  parameter int ALUOP_WIDTH  = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    mem_ready,
  output logic                    pc_write,
  output logic                    pc_write_cond,
  output logic                    i_or_d,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    ir_write,
  output logic                    mem_to_reg,
  output logic                    reg_dst,
  output logic                    reg_write,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [1:0]              pc_src,
  output logic [ALUOP_WIDTH-1:0]  alu_op,
  output logic [3:0]              state,
  output logic [CNT_WIDTH-1:0]    instr_count,
  output logic                    illegal_op
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMRD    = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWR    = 4'd6;
  localparam logic [3:0] S_EXECUTE  = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_ADDIEXEC = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [3:0] S_TRAP     = 4'd13;

  // MIPS opcodes, zero-extended to the configured opcode width
  localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
  localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(0);
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(2);

  logic [3:0] next_state;
  logic       retire;

  // Next-state selection; opcode is only looked at in DECODE and MEMADR
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:     next_state = S_FETCH;
      S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) next_state = S_MEMADR;
        else if (opcode == OP_R)                next_state = S_EXECUTE;
        else if (opcode == OP_BEQ)              next_state = S_BRANCH;
        else if (opcode == OP_ADDI)             next_state = S_ADDIEXEC;
        else if (opcode == OP_J)                next_state = S_JUMP;
        else begin
`ifdef ILLEGAL_OP_TRAP_EN
          next_state = S_TRAP;
`else
          next_state = S_FETCH;
`endif
        end
      end
      // anything other than lw that reaches MEMADR is treated as a store
      S_MEMADR:   next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWR:    next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_ADDIEXEC: next_state = S_ADDIWB;
      S_ADDIWB:   next_state = S_FETCH;
      S_JUMP:     next_state = S_FETCH;
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_IDLE;
    endcase
  end

  // An instruction retires whenever control returns to FETCH from a working state
  assign retire = (next_state == S_FETCH) && (state != S_IDLE) && (state != S_FETCH);

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + 1'b1;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  // Sticky illegal-opcode flag, set on entry to TRAP
  always_ff @(posedge clk) begin
    if (reset)                     illegal_op <= 1'b0;
    else if (next_state == S_TRAP) illegal_op <= 1'b1;
  end
`else
  assign illegal_op = 1'b0;
`endif

  // Moore control decode; only the FETCH IR/PC strobes wait on mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

endmodule
